// File: rtl/gtxe2_chnl_oob_pkg.sv
// Shared OOB timing constants and sequence-class encoding for the GTXE2 channel
// TX and RX out-of-band blocks.
package gtxe2_chnl_oob_pkg;

  localparam int OOB_BURST_LEN    = 8;
  localparam int OOB_WAKE_GAP_LEN = 8;
  localparam int OOB_INIT_GAP_LEN = 24;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_INIT = 2'd1,
    CLS_WAKE = 2'd2
  } oob_cls_t;

  // Every supported CPLL VCO setting yields the same OOB cycle counts.
  function automatic int burst_len_mult(input string cfg);
    if (cfg == "VCO_3000MHZ") begin
      burst_len_mult = 1;
    end else if (cfg == "VCO_2500MHZ") begin
      burst_len_mult = 1;
    end else begin
      burst_len_mult = 1;
    end
  endfunction

endpackage

// File: rtl/gtxe2_chnl_rx_oob_classify.sv
// Combinational window decode of the RX OOB length counter: burst acceptance
// and wake / init gap classification.
module gtxe2_chnl_rx_oob_classify
  import gtxe2_chnl_oob_pkg::*;
#(
  parameter int OOB_TOL      = 2,
  parameter int OOB_INIT_TOL = 4,
  parameter int LEN_MULT     = 1
) (
  input  logic [5:0] len_cnt,
  output logic       is_wake,
  output logic       is_init,
  output logic       burst_ok
);

  localparam logic [5:0] BURST_MIN = 6'(OOB_BURST_LEN * LEN_MULT - OOB_TOL);
  localparam logic [5:0] BURST_MAX = 6'(OOB_BURST_LEN * LEN_MULT + OOB_TOL);
  localparam logic [5:0] WAKE_MIN  = 6'(OOB_WAKE_GAP_LEN * LEN_MULT - OOB_TOL);
  localparam logic [5:0] WAKE_MAX  = 6'(OOB_WAKE_GAP_LEN * LEN_MULT + OOB_TOL);
  localparam logic [5:0] INIT_MIN  = 6'(OOB_INIT_GAP_LEN * LEN_MULT - OOB_INIT_TOL);
  localparam logic [5:0] INIT_MAX  = 6'(OOB_INIT_GAP_LEN * LEN_MULT + OOB_INIT_TOL);

  always_comb begin
    burst_ok = (len_cnt >= BURST_MIN) && (len_cnt <= BURST_MAX);
    is_wake  = (len_cnt >= WAKE_MIN)  && (len_cnt <= WAKE_MAX);
    is_init  = (len_cnt >= INIT_MIN)  && (len_cnt <= INIT_MAX);
  end

endmodule

// File: rtl/gtxe2_chnl_rx_oob.sv
// RX OOB detector: measures burst/gap lengths of the squelch idle indication and
// pulses RXCOMINITDET / RXCOMWAKEDET once a full, cleanly terminated sequence is seen.
module gtxe2_chnl_rx_oob
  import gtxe2_chnl_oob_pkg::*;
#(
  parameter logic [3:0] SATA_BURST_SEQ_LEN = 4'b0101,
  parameter string      SATA_CPLL_CFG      = "VCO_3000MHZ",
  parameter int         OOB_TOL            = 2,
  parameter int         OOB_INIT_TOL       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_in,
  output logic RXCOMINITDET,
  output logic RXCOMWAKEDET,
  output logic oob_busy
);

  localparam int         LEN_MULT  = burst_len_mult(SATA_CPLL_CFG);
  localparam logic [5:0] BURST_MAX = 6'(OOB_BURST_LEN * LEN_MULT + OOB_TOL);
  localparam logic [5:0] INIT_MAX  = 6'(OOB_INIT_GAP_LEN * LEN_MULT + OOB_INIT_TOL);
  localparam logic [5:0] WAKE_END  = 6'(OOB_WAKE_GAP_LEN * LEN_MULT + OOB_TOL + 1);
  localparam logic [5:0] INIT_END  = 6'(OOB_INIT_GAP_LEN * LEN_MULT + OOB_INIT_TOL + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state;
  oob_cls_t   cls;
  oob_cls_t   gap_cls;
  logic [5:0] len_cnt;
  logic [5:0] len_inc;
  logic [5:0] gap_end;
  logic [3:0] bursts;
  logic       is_wake;
  logic       is_init;
  logic       burst_ok;
  logic       gap_ok;

  gtxe2_chnl_rx_oob_classify #(
    .OOB_TOL      (OOB_TOL),
    .OOB_INIT_TOL (OOB_INIT_TOL),
    .LEN_MULT     (LEN_MULT)
  ) u_classify (
    .len_cnt  (len_cnt),
    .is_wake  (is_wake),
    .is_init  (is_init),
    .burst_ok (burst_ok)
  );

  always_comb begin
    len_inc = (len_cnt == 6'd63) ? 6'd63 : len_cnt + 6'd1;
    gap_end = (cls == CLS_WAKE) ? WAKE_END : INIT_END;
    if (is_wake) begin
      gap_cls = CLS_WAKE;
    end else if (is_init) begin
      gap_cls = CLS_INIT;
    end else begin
      gap_cls = CLS_NONE;
    end
    // A gap extends the candidate only if it matches the class already locked in.
    gap_ok = (gap_cls != CLS_NONE) && ((cls == CLS_NONE) || (gap_cls == cls))
             && (bursts < SATA_BURST_SEQ_LEN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cls          <= CLS_NONE;
      len_cnt      <= 6'd0;
      bursts       <= 4'd0;
      RXCOMINITDET <= 1'b0;
      RXCOMWAKEDET <= 1'b0;
      oob_busy     <= 1'b0;
    end else begin
      RXCOMINITDET <= 1'b0;
      RXCOMWAKEDET <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!idle_in) begin
            state    <= ST_BURST;
            len_cnt  <= 6'd1;
            bursts   <= 4'd0;
            cls      <= CLS_NONE;
            oob_busy <= 1'b1;
          end
        end
        ST_BURST: begin
          if (!idle_in) begin
            if (len_cnt >= BURST_MAX) begin
              state    <= ST_IDLE;
              oob_busy <= 1'b0;
            end else begin
              len_cnt <= len_inc;
            end
          end else if (burst_ok) begin
            state   <= ST_GAP;
            bursts  <= bursts + 4'd1;
            len_cnt <= 6'd1;
          end else begin
            state    <= ST_IDLE;
            oob_busy <= 1'b0;
          end
        end
        ST_GAP: begin
          if (idle_in) begin
            len_cnt <= len_inc;
            if ((bursts == SATA_BURST_SEQ_LEN) && (len_inc == gap_end)) begin
              RXCOMINITDET <= (cls == CLS_INIT);
              RXCOMWAKEDET <= (cls == CLS_WAKE);
              state        <= ST_IDLE;
              oob_busy     <= 1'b0;
            end else if ((bursts < SATA_BURST_SEQ_LEN) && (len_inc > INIT_MAX)) begin
              state    <= ST_IDLE;
              oob_busy <= 1'b0;
            end
          end else begin
            // Either way the new burst is counted; a rejected gap starts a fresh candidate.
            state   <= ST_BURST;
            len_cnt <= 6'd1;
            if (gap_ok) begin
              cls <= gap_cls;
            end else begin
              bursts <= 4'd0;
              cls    <= CLS_NONE;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          oob_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
